// File: rtl/spd_window_mon.sv
// Multi-channel wheel-speed window monitor: per-channel window averages, cross-channel spread and lean-trend checks.
// Optional spread comparator is compiled in only when SPD_WINDOW_SPREAD_EN is defined.
module spd_window_mon #(
    parameter int NUM_CH      = 2,
    parameter int SPD_W       = 12,
    parameter int LOG2_WIN    = 10,
    parameter int SPREAD_TOL  = 10,
    parameter int REF_W       = 16,
    parameter int REF_TOL_POS = 100,
    parameter int REF_TOL_NEG = 250
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    start,
    input  logic                    smpl_vld,
    input  logic [NUM_CH*SPD_W-1:0] spd,
    input  logic [REF_W-1:0]        ref_val,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_CH*SPD_W-1:0] avg,
    output logic                    spread_err,
    output logic                    trend_err,
    output logic                    trend_skip
);

    localparam int ACC_W = SPD_W + LOG2_WIN;
    localparam logic [REF_W:0] TOL_POS = (REF_W+1)'(REF_TOL_POS);
    localparam logic [REF_W:0] TOL_NEG = (REF_W+1)'(REF_TOL_NEG);

    typedef enum logic [1:0] {IDLE, ACCUM, EVAL, REPORT} state_t;

    state_t                    state;
    logic signed [ACC_W-1:0]   acc [NUM_CH];
    logic [LOG2_WIN-1:0]       cnt;
    logic signed [REF_W-1:0]   cur_ref;
    logic signed [REF_W-1:0]   prev_ref;
    logic [NUM_CH*SPD_W-1:0]   prev_avg;
    logic                      first;

    logic [NUM_CH*SPD_W-1:0]   avg_nxt;
    logic                      any_le;
    logic                      any_ge;
    logic signed [REF_W:0]     ref_diff;
    logic [REF_W:0]            ref_dist;
    logic                      in_band;
    logic                      rising;

    always_comb begin
        avg_nxt = '0;
        any_le  = 1'b0;
        any_ge  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            avg_nxt[i*SPD_W +: SPD_W] = SPD_W'(acc[i] >>> LOG2_WIN);
            if ($signed(avg_nxt[i*SPD_W +: SPD_W]) <= $signed(prev_avg[i*SPD_W +: SPD_W]))
                any_le = 1'b1;
            if ($signed(avg_nxt[i*SPD_W +: SPD_W]) >= $signed(prev_avg[i*SPD_W +: SPD_W]))
                any_ge = 1'b1;
        end
        // One extra bit keeps the reference difference and its magnitude exact.
        ref_diff = {cur_ref[REF_W-1], cur_ref} - {prev_ref[REF_W-1], prev_ref};
        ref_dist = ref_diff[REF_W] ? (REF_W+1)'(-ref_diff) : (REF_W+1)'(ref_diff);
        in_band  = (cur_ref[REF_W-1] && prev_ref[REF_W-1]) ? (ref_dist <= TOL_NEG)
                                                           : (ref_dist <= TOL_POS);
        rising   = cur_ref > prev_ref;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_ref    <= '0;
            prev_ref   <= '0;
            prev_avg   <= '0;
            first      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            avg        <= '0;
            trend_err  <= 1'b0;
            trend_skip <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= ACCUM;
                        busy    <= 1'b1;
                        cur_ref <= ref_val;
                        cnt     <= '0;
                        for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
                    end
                end
                ACCUM: begin
                    if (smpl_vld) begin
                        for (int i = 0; i < NUM_CH; i++)
                            acc[i] <= acc[i] + ACC_W'($signed(spd[i*SPD_W +: SPD_W]));
                        cnt <= cnt + 1'b1;
                        if (cnt == {LOG2_WIN{1'b1}}) state <= EVAL;
                    end
                end
                EVAL: begin
                    avg      <= avg_nxt;
                    prev_avg <= avg_nxt;
                    prev_ref <= cur_ref;
                    first    <= 1'b0;
                    if (first || in_band) begin
                        trend_skip <= 1'b1;
                        trend_err  <= 1'b0;
                    end else begin
                        trend_skip <= 1'b0;
                        trend_err  <= rising ? any_le : any_ge;
                    end
                    done  <= 1'b1;
                    state <= REPORT;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPD_WINDOW_SPREAD_EN
    logic signed [SPD_W-1:0] spd_max;
    logic signed [SPD_W-1:0] spd_min;
    logic signed [SPD_W:0]   spread;
    logic                    spread_hit;

    always_comb begin
        spd_max = $signed(spd[SPD_W-1:0]);
        spd_min = $signed(spd[SPD_W-1:0]);
        for (int i = 1; i < NUM_CH; i++) begin
            if ($signed(spd[i*SPD_W +: SPD_W]) > spd_max) spd_max = $signed(spd[i*SPD_W +: SPD_W]);
            if ($signed(spd[i*SPD_W +: SPD_W]) < spd_min) spd_min = $signed(spd[i*SPD_W +: SPD_W]);
        end
        spread     = {spd_max[SPD_W-1], spd_max} - {spd_min[SPD_W-1], spd_min};
        spread_hit = spread > (SPD_W+1)'(SPREAD_TOL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            spread_err <= 1'b0;
        else if (state == ACCUM && smpl_vld && spread_hit)
            spread_err <= 1'b1;
    end
`else
    assign spread_err = 1'b0;
`endif

endmodule

// File: tb/tb_spd_window_mon.sv
// Scoreboard bench for spd_window_mon (LOG2_WIN=4, two channels): driver pushes expected window results, monitor checks them on done.
module tb_spd_window_mon;

    localparam int SPD_W = 12;
    localparam int NCH   = 2;
    localparam int LW    = 4;
`ifdef SPD_WINDOW_SPREAD_EN
    localparam int SP_EXP = 1;
`else
    localparam int SP_EXP = 0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  clr = 1'b0;
    logic                  start = 1'b0;
    logic                  smpl_vld = 1'b0;
    logic [NCH*SPD_W-1:0]  spd = '0;
    logic [15:0]           ref_val = '0;
    logic                  busy;
    logic                  done;
    logic [NCH*SPD_W-1:0]  avg;
    logic                  spread_err;
    logic                  trend_err;
    logic                  trend_skip;

    spd_window_mon #(.NUM_CH(NCH), .SPD_W(SPD_W), .LOG2_WIN(LW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .smpl_vld(smpl_vld),
        .spd(spd), .ref_val(ref_val), .busy(busy), .done(done), .avg(avg),
        .spread_err(spread_err), .trend_err(trend_err), .trend_skip(trend_skip)
    );

    typedef struct {
        int a0; int a1; int te; int ts; int sp; int cyc;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   s0[16];
    int   s1[16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int a, input int b);
        for (int i = 0; i < 16; i++) begin
            s0[i] = a;
            s1[i] = b;
        end
    endtask

    // gap idle cycles precede every strobe; sp_idx selects the strobe after which spread_err is checked
    task automatic run_window(input int r, input int gap, input bit mid_start, input int sp_idx,
                              input int e_a0, input int e_a1, input int e_te, input int e_ts,
                              input int e_sp);
        exp_t e;
        start   = 1'b1;
        ref_val = 16'(r);
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < gap; g++) begin
                start = mid_start && (i == 8) && (g == 0);
                tick();
            end
            start    = 1'b0;
            smpl_vld = 1'b1;
            spd      = {12'(s1[i]), 12'(s0[i])};
            tick();
            smpl_vld = 1'b0;
            if (i == sp_idx) chk("spread_next_cycle", spread_err, e_sp);
        end
        e = '{e_a0, e_a1, e_te, e_ts, e_sp, cyc + 1};
        q.push_back(e);
        tick();
        tick();
        chk("busy_after_report", busy, 0);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
            end else begin
                m_e = q.pop_front();
                chk("done_cycle", cyc, m_e.cyc);
                chk("avg0", $signed(avg[SPD_W-1:0]), m_e.a0);
                chk("avg1", $signed(avg[2*SPD_W-1:SPD_W]), m_e.a1);
                chk("trend_err", trend_err, m_e.te);
                chk("trend_skip", trend_skip, m_e.ts);
                chk("spread_err", spread_err, m_e.sp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_avg", int'(avg), 0);
        chk("rst_spread", spread_err, 0);
        chk("rst_trend_err", trend_err, 0);
        chk("rst_trend_skip", trend_skip, 0);

        // First window, constant speed
        fill(100, 100);
        run_window(0, 0, 1'b0, -1, 100, 100, 0, 1, 0);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_avg", int'(avg), 0);
        chk("clr_trend_skip", trend_skip, 0);

        // Trend sequence
        fill(50, 50);
        run_window(0, 0, 1'b0, -1, 50, 50, 0, 1, 0);
        fill(80, 80);
        s1[5] = 90;                     // spread exactly at tolerance must not trip
        run_window(500, 0, 1'b0, 5, 80, 80, 0, 0, 0);
        fill(70, 70);
        run_window(1000, 0, 1'b0, -1, 70, 70, 1, 0, 0);
        fill(90, 90);
        run_window(-300, 0, 1'b0, -1, 90, 90, 1, 0, 0);
        fill(100, 100);
        run_window(-500, 0, 1'b0, -1, 100, 100, 0, 1, 0);
        run_window(0, 0, 1'b0, -1, 100, 100, 1, 0, 0);
        run_window(150, 0, 1'b0, -1, 100, 100, 1, 0, 0);
        fill(60, 60);
        run_window(-200, 0, 1'b0, -1, 60, 60, 0, 0, 0);

        // Floor averaging with sparse strobes and an ignored mid-window start
        for (int i = 0; i < 16; i++) begin
            s0[i] = (i % 2 == 1) ? -8 : -7;
            s1[i] = (i % 2 == 1) ? -7 : -8;
        end
        run_window(-200, 2, 1'b1, -1, -8, -8, 0, 1, 0);

        // Spread violation, sticky until clr
        fill(100, 100);
        s1[3] = 111;
        run_window(-200, 0, 1'b0, 3, 100, 100, 0, 1, SP_EXP);
        tick();
        tick();
        chk("spread_held", spread_err, SP_EXP);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("spread_clr", spread_err, 0);

        // Reset mid-window: abandoned, next window is a first window
        start   = 1'b1;
        ref_val = 16'(0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            smpl_vld = 1'b1;
            spd      = {12'(30), 12'(30)};
            tick();
        end
        smpl_vld = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_avg", int'(avg), 0);
        chk("midrst_trend_err", trend_err, 0);
        chk("midrst_trend_skip", trend_skip, 0);
        repeat (20) tick();
        fill(30, 30);
        run_window(700, 0, 1'b0, -1, 30, 30, 0, 1, 0);

        repeat (3) tick();
        chk("missing_done", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
